// File: rtl/text_console_buffer.sv
// text_console_buffer: COLS x ROWS character-cell RAM with cursor tracking and control-code handling.
// Define TEXT_CONSOLE_SCROLL_EN to scroll through a top-row base register instead of wrapping to row 0.
module text_console_buffer #(
   parameter int unsigned       COLS    = 16,
   parameter int unsigned       ROWS    = 12,
   parameter int unsigned       CELL_PX = 40,
   parameter int unsigned       DATA_W  = 8,
   parameter logic [DATA_W-1:0] BLANK   = 8'h20
) (
   input  logic                    iCLK,
   input  logic                    iRST_N,
   input  logic [DATA_W-1:0]       iChar,
   input  logic                    iChar_Valid,
   output logic                    oChar_Ready,
   input  logic [$clog2(COLS)-1:0] iRd_Col,
   input  logic [$clog2(ROWS)-1:0] iRd_Row,
   output logic [DATA_W-1:0]       oRd_Char,
   output logic [$clog2(COLS)-1:0] oCur_Col,
   output logic [$clog2(ROWS)-1:0] oCur_Row,
   output logic [9:0]              oCur_X,
   output logic [9:0]              oCur_Y,
   output logic                    oBusy
);
   localparam int unsigned CW    = $clog2(COLS);
   localparam int unsigned RW    = $clog2(ROWS);
   localparam int unsigned DEPTH = COLS * ROWS;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
   localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [7:0] CODE_BS = 8'h08;
   localparam logic [7:0] CODE_CR = 8'h0D;
   localparam logic [7:0] CODE_FF = 8'h0C;

`ifdef TEXT_CONSOLE_SCROLL_EN
   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_CLRROW} state_t;
`else
   typedef enum logic [1:0] {S_CLEAR, S_IDLE} state_t;
`endif

   state_t            state, state_nxt;
   logic [CW-1:0]     cur_col, col_nxt;
   logic [RW-1:0]     cur_row, row_nxt;
   logic [AW-1:0]     clr_addr;
   logic [AW-1:0]     wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              we;
   logic              transfer;
   logic              row_adv;
   logic [7:0]        code;
   logic [DATA_W-1:0] mem [DEPTH];

`ifdef TEXT_CONSOLE_SCROLL_EN
   logic [RW-1:0] base, base_nxt;
   logic [CW-1:0] clr_cnt;
   logic          row_wrap;

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         base    <= '0;
         clr_cnt <= '0;
      end else begin
         base    <= base_nxt;
         clr_cnt <= (state == S_CLRROW) ? clr_cnt + 1'b1 : '0;
      end
   end

   assign row_wrap = row_adv && (cur_row == LAST_ROW);
`else
   logic [RW-1:0] base;
   assign base = '0;
`endif

   // Screen row is rotated by the top-row base before forming the physical address.
   function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] row, input logic [CW-1:0] col,
                                               input logic [RW-1:0] top);
      logic [RW:0] prow;
      prow = {1'b0, row} + {1'b0, top};
      if (prow >= (RW+1)'(ROWS)) prow = prow - (RW+1)'(ROWS);
      return AW'(prow) * AW'(COLS) + AW'(col);
   endfunction

   assign code     = iChar[7:0];
   assign transfer = iChar_Valid && (state == S_IDLE);
   assign row_adv  = transfer && ((code == CODE_CR) ||
                     ((code != CODE_BS) && (code != CODE_FF) && (cur_col == LAST_COL)));

   always_ff @(posedge iCLK) begin
      if (!iRST_N) state <= S_CLEAR;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_CLEAR: if (clr_addr == LAST_ADDR) state_nxt = S_IDLE;
         S_IDLE: begin
            if (transfer && (code == CODE_FF)) state_nxt = S_CLEAR;
`ifdef TEXT_CONSOLE_SCROLL_EN
            else if (row_wrap) state_nxt = S_CLRROW;
`endif
         end
`ifdef TEXT_CONSOLE_SCROLL_EN
         S_CLRROW: if (clr_cnt == LAST_COL) state_nxt = S_IDLE;
`endif
         default: state_nxt = S_CLEAR;
      endcase
   end

   always_comb begin
      oChar_Ready = (state == S_IDLE);
      oBusy       = (state == S_CLEAR);
      we          = 1'b0;
      wr_addr     = clr_addr;
      wr_data     = BLANK;
      case (state)
         S_IDLE: begin
            if (transfer && (code == CODE_BS)) begin
               we      = 1'b1;
               wr_addr = cell_addr(row_nxt, col_nxt, base);
            end else if (transfer && (code != CODE_CR) && (code != CODE_FF)) begin
               we      = 1'b1;
               wr_addr = cell_addr(cur_row, cur_col, base);
               wr_data = iChar;
            end
         end
         default: we = 1'b1;
      endcase
   end

   always_comb begin
      col_nxt = cur_col;
      row_nxt = cur_row;
`ifdef TEXT_CONSOLE_SCROLL_EN
      base_nxt = base;
`endif
      if (transfer) begin
         case (code)
            CODE_BS: begin
               if (cur_col != '0) begin
                  col_nxt = cur_col - 1'b1;
               end else if (cur_row != '0) begin
                  col_nxt = LAST_COL;
                  row_nxt = cur_row - 1'b1;
               end
            end
            CODE_CR: col_nxt = '0;
            CODE_FF: begin
               col_nxt = '0;
               row_nxt = '0;
`ifdef TEXT_CONSOLE_SCROLL_EN
               base_nxt = '0;
`endif
            end
            default: col_nxt = (cur_col == LAST_COL) ? '0 : cur_col + 1'b1;
         endcase
         if (row_adv) begin
            if (cur_row != LAST_ROW) row_nxt = cur_row + 1'b1;
`ifdef TEXT_CONSOLE_SCROLL_EN
            else base_nxt = (base == LAST_ROW) ? '0 : base + 1'b1;
`else
            else row_nxt = '0;
`endif
         end
      end
   end

   // In IDLE the sweep pointer is preloaded: 0 for a full clear, the old top row for a scroll.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         cur_col  <= '0;
         cur_row  <= '0;
         clr_addr <= '0;
      end else begin
         cur_col <= col_nxt;
         cur_row <= row_nxt;
         if (state == S_IDLE) clr_addr <= (state_nxt == S_CLEAR) ? '0 : AW'(base) * AW'(COLS);
         else                 clr_addr <= clr_addr + 1'b1;
      end
   end

   always_ff @(posedge iCLK) begin
      if (we && iRST_N) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) oRd_Char <= '0;
      else         oRd_Char <= mem[cell_addr(iRd_Row, iRd_Col, base)];
   end

   assign oCur_Col = cur_col;
   assign oCur_Row = cur_row;
   assign oCur_X   = 10'(cur_col) * 10'(CELL_PX);
   assign oCur_Y   = 10'(cur_row) * 10'(CELL_PX);

endmodule
